// File: rtl/vliw_fetch_stage.sv
// Instruction fetch for the two-slot VLIW core: credit-limited in-order imem
// requests, a small bundle buffer ahead of IF/ID, and redirect squash of in-flight responses.
module vliw_fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned BUNDLE_BYTES    = 6,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [47:0] imem_rsp_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr1,
  output logic [15:0] out_instr2,
  output logic        if_write,
  output logic        if_flush
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [QW-1:0] QLAST_C = QW'(MAX_OUTSTANDING - 1);
  localparam logic [PW-1:0] PONE_C  = PW'(1);

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } state_e;

  state_e        state_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [QW-1:0] pcq_rd_q, pcq_rd_d;
  logic [QW-1:0] pcq_wr_q, pcq_wr_d;

  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [47:0]   fifo_data_q [FIFO_DEPTH];
  logic [31:0]   pcq_q       [MAX_OUTSTANDING];

  logic          run;
  logic [CW-1:0] live;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [31:0]   head_pc;
  logic [47:0]   head_data;

  function automatic logic [QW-1:0] pcq_next(input logic [QW-1:0] ptr);
    return (ptr == QLAST_C) ? '0 : ptr + QW'(1);
  endfunction

  // Credit counts both live in-flight requests and buffered bundles, so a
  // response always finds a free FIFO slot.
  always_comb begin
    run            = (state_q == ST_RUN) && !reset;
    live           = outst_q - drop_q;
    credit_ok      = (outst_q < MAXO_C) && ((live + count_q) < DEPTH_C);
    imem_req_valid = run && !redirect_valid && credit_ok;
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;

    rsp_take       = imem_rsp_valid && (outst_q != '0) && !reset;
    rsp_drop       = rsp_take && ((drop_q != '0) || redirect_valid);
    push           = rsp_take && !rsp_drop;

    fifo_empty     = (count_q == '0);
    head_pc        = fifo_pc_q[rd_ptr_q];
    head_data      = fifo_data_q[rd_ptr_q];
    out_valid      = !fifo_empty && !redirect_valid && !reset;
    out_pc         = (fifo_empty || reset) ? 32'h0 : head_pc;
    out_instr1     = (fifo_empty || reset) ? 32'h0 : head_data[47:16];
    out_instr2     = (fifo_empty || reset) ? 16'h0 : head_data[15:0];
    pop            = out_valid && !stall;

    if_write       = run && !stall;
    if_flush       = redirect_valid && !reset;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pcq_rd_d   = pcq_rd_q;
    pcq_wr_d   = pcq_wr_q;
    outst_d    = outst_q + (req_fire ? ONE_C : '0) - (rsp_take ? ONE_C : '0);

    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the wrong path.
      fetch_pc_d = redirect_pc;
      drop_d     = outst_q - (rsp_take ? ONE_C : '0);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'(BUNDLE_BYTES);
      end
      if (rsp_take && (drop_q != '0)) begin
        drop_d = drop_q - ONE_C;
      end
      count_d = count_q + (push ? ONE_C : '0) - (pop ? ONE_C : '0);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PONE_C;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PONE_C;
      end
    end

    if (req_fire) begin
      pcq_wr_d = pcq_next(pcq_wr_q);
    end
    if (rsp_take) begin
      pcq_rd_d = pcq_next(pcq_rd_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
    end else begin
      state_q    <= ST_RUN;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pcq_rd_q   <= pcq_rd_d;
      pcq_wr_q   <= pcq_wr_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters alone.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq_q[pcq_wr_q] <= fetch_pc_q;
    end
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= pcq_q[pcq_rd_q];
      fifo_data_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && (count_q == DEPTH_C)));
      assert (!(req_fire && (outst_q == MAXO_C)));
    end
  end

endmodule

// File: tb/tb_vliw_fetch_stage.sv
// Bench for vliw_fetch_stage: variable-latency memory model plus a queue-based
// reference of the bundle stream, credit and redirect rules.
module tb_vliw_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int BB    = 6;
  localparam int DEPTH = 2;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] redirect_pc;
  logic [47:0] imem_rsp_data;
  logic        imem_req_valid, out_valid, if_write, if_flush;
  logic [31:0] imem_req_addr, out_pc, out_instr1;
  logic [15:0] out_instr2;

  vliw_fetch_stage #(
    .RESET_PC(RESET_PC), .BUNDLE_BYTES(BB), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr1(out_instr1), .out_instr2(out_instr2),
    .if_write(if_write), .if_flush(if_flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int phase = 0;
  bit reset_v, stall_v, redir_v, ready_v;
  logic [31:0] redir_pc_v;
  int lat_min, lat_max, hold_pct;

  logic [31:0] mq_addr[$];
  logic [31:0] mq_mpc[$];
  int          mq_due[$];
  bit          mq_stale[$];
  logic [31:0] fq[$];
  logic [31:0] m_addr;

  bit          chk, rsp_now, popped, fired;
  logic        e_ov, e_rv, e_wr, e_fl, e_empty;
  logic [31:0] e_pc, e_i1, e_addr;
  logic [15:0] e_i2;
  logic        o_ov, o_rv, o_wr, o_fl;
  logic [31:0] o_pc, o_i1, o_addr;
  logic [15:0] o_i2;

  function automatic logic [47:0] bundle_of(input logic [31:0] a);
    return {a ^ 32'h5A5A_0F0F, a[15:0] ^ a[31:16] ^ 16'hC3C3};
  endfunction

  // One clock: drive at negedge, sample, predict, then advance the model at posedge.
  task automatic step();
    int          live;
    logic [47:0] eb;
    logic [31:0] a;
    bit          st;
    @(negedge clk);
    reset          = reset_v;
    stall          = stall_v;
    redirect_valid = redir_v;
    redirect_pc    = redir_pc_v;
    imem_req_ready = ready_v;
    rsp_now = !reset_v && (mq_due.size() > 0) && (mq_due[0] <= cyc) &&
              (int'($urandom_range(99)) >= hold_pct);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? bundle_of(mq_addr[0]) : {16'($urandom), 32'($urandom)};
    #1;
    o_ov = out_valid; o_rv = imem_req_valid; o_wr = if_write; o_fl = if_flush;
    o_pc = out_pc; o_i1 = out_instr1; o_i2 = out_instr2; o_addr = imem_req_addr;

    chk = !reset_v && (phase != 0);
    live = 0;
    foreach (mq_stale[i]) if (!mq_stale[i]) live++;
    e_empty = (fq.size() == 0);
    e_ov    = !e_empty && !redir_v;
    e_pc    = e_empty ? 32'h0 : fq[0];
    eb      = e_empty ? 48'h0 : bundle_of(fq[0]);
    e_i1    = eb[47:16];
    e_i2    = eb[15:0];
    e_rv    = (phase == 2) && !redir_v && (mq_due.size() < MAXO) && ((live + fq.size()) < DEPTH);
    e_wr    = (phase == 2) && !stall_v;
    e_fl    = redir_v;
    e_addr  = m_addr;
    popped  = !reset_v && o_ov && !stall_v;
    fired   = !reset_v && o_rv && ready_v;

    if (reset_v) begin
      mq_addr.delete(); mq_mpc.delete(); mq_due.delete(); mq_stale.delete();
      fq.delete();
      m_addr = RESET_PC;
      phase  = 1;
    end else begin
      if (e_ov && !stall_v) void'(fq.pop_front());
      if (rsp_now) begin
        a = mq_mpc.pop_front();
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
        st = mq_stale.pop_front();
        if (!st && !redir_v) fq.push_back(a);
      end
      if (fired) begin
        mq_addr.push_back(o_addr);
        mq_mpc.push_back(m_addr);
        mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        mq_stale.push_back(1'b0);
        m_addr = m_addr + BB;
      end
      if (redir_v) begin
        fq.delete();
        foreach (mq_stale[i]) mq_stale[i] = 1'b1;
        m_addr = redir_pc_v;
      end
      if (phase == 1) phase = 2;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    logic [47:0] b0;
    bit got;
    reset_v = 1; stall_v = 0; redir_v = 0; ready_v = 1; redir_pc_v = 32'h0;
    lat_min = 1; lat_max = 1; hold_pct = 0;
    step(); step();
    reset_v = 0;
    step();
    checks++; if (o_rv !== 1'b0) begin errors++; $display("FAIL boot_req_valid: got %b expected 0", o_rv); end
    checks++; if ({o_ov, o_wr, o_fl} !== 3'b000) begin errors++; $display("FAIL boot_ctrl: got ov/wr/fl=%b expected 000", {o_ov, o_wr, o_fl}); end
    checks++; if ({o_pc, o_i1, o_i2} !== 80'h0) begin errors++; $display("FAIL boot_nop: got %h %h %h expected zeros", o_pc, o_i1, o_i2); end
    step();
    checks++; if (o_rv !== 1'b1 || o_addr !== RESET_PC) begin errors++; $display("FAIL first_req: got valid=%b addr=%h expected 1 %h", o_rv, o_addr, RESET_PC); end
    step();
    checks++; if (o_ov !== 1'b0) begin errors++; $display("FAIL first_bundle_early: got out_valid=%b expected 0", o_ov); end
    step();
    b0 = bundle_of(RESET_PC);
    checks++; if (o_ov !== 1'b1 || o_pc !== RESET_PC || {o_i1, o_i2} !== b0) begin errors++; $display("FAIL first_bundle: got ov=%b pc=%h data=%h expected 1 %h %h", o_ov, o_pc, {o_i1, o_i2}, RESET_PC, b0); end
    checks++; if (o_wr !== 1'b1 || o_fl !== 1'b0) begin errors++; $display("FAIL ifid_ctrl: got wr=%b flush=%b expected 1 0", o_wr, o_fl); end
    step();
    checks++; if (o_ov !== 1'b1 || o_pc !== RESET_PC + 32'd6) begin errors++; $display("FAIL second_bundle: got ov=%b pc=%h expected 1 %h", o_ov, o_pc, RESET_PC + 32'd6); end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin step(); got = popped; end
    checks++; if (!got || o_pc !== RESET_PC + 32'd12) begin errors++; $display("FAIL third_bundle: got popped=%b pc=%h expected 1 %h", got, o_pc, RESET_PC + 32'd12); end
  endtask

  task automatic test_stall();
    logic [31:0] first_pc;
    logic [31:0] pcs[4];
    int n;
    stall_v = 1;
    for (int i = 0; i < 20 && fq.size() < 2; i++) step();
    checks++; if (fq.size() != 2) begin errors++; $display("FAIL stall_fill: got %0d buffered expected 2", fq.size()); end
    first_pc = fq[0];
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (o_ov !== 1'b1 || o_pc !== first_pc || o_rv !== 1'b0 || o_wr !== 1'b0) begin
        errors++; $display("FAIL stall_hold: got ov=%b pc=%h rv=%b wr=%b expected 1 %h 0 0", o_ov, o_pc, o_rv, o_wr, first_pc);
      end
    end
    stall_v = 0;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin step(); if (popped) begin pcs[n] = o_pc; n++; end end
    for (int k = 0; k < 4; k++) begin
      checks++; if (k >= n || pcs[k] !== first_pc + 32'(6 * k)) begin errors++; $display("FAIL stall_release_%0d: got %h expected %h", k, pcs[k], first_pc + 32'(6 * k)); end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] pcs[2];
    int n;
    bit got;
    stall_v = 0; lat_min = 3; lat_max = 3;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin step(); got = (mq_due.size() == 2); end
    checks++; if (!got) begin errors++; $display("FAIL redirect_setup: got %0d in flight expected 2", mq_due.size()); end
    redir_v = 1; redir_pc_v = 32'h100;
    step();
    redir_v = 0;
    checks++; if (o_fl !== 1'b1 || o_ov !== 1'b0 || o_rv !== 1'b0) begin errors++; $display("FAIL redirect_cycle: got fl=%b ov=%b rv=%b expected 1 0 0", o_fl, o_ov, o_rv); end
    n = 0;
    for (int i = 0; i < 60 && n < 2; i++) begin step(); if (popped) begin pcs[n] = o_pc; n++; end end
    checks++; if (n < 2 || pcs[0] !== 32'h100 || pcs[1] !== 32'h106) begin errors++; $display("FAIL redirect_target: got n=%0d %h %h expected 00000100 00000106", n, pcs[0], pcs[1]); end
  endtask

  task automatic test_redirect_rsp_same_cycle();
    bit got;
    lat_min = 2; lat_max = 2; stall_v = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      got = (mq_due.size() > 0) && (mq_due[0] <= cyc);
      if (!got) step();
    end
    checks++; if (!got) begin errors++; $display("FAIL same_cycle_setup: got no due response expected one"); end
    redir_v = 1; redir_pc_v = 32'h2000;
    step();
    redir_v = 0;
    checks++; if (o_fl !== 1'b1 || o_ov !== 1'b0) begin errors++; $display("FAIL same_cycle_flush: got fl=%b ov=%b expected 1 0", o_fl, o_ov); end
    step();
    checks++; if (o_rv !== e_rv) begin errors++; $display("FAIL same_cycle_credit: got rv=%b expected %b", o_rv, e_rv); end
    got = popped;
    for (int i = 0; i < 40 && !got; i++) begin step(); got = popped; end
    checks++; if (!got || o_pc !== 32'h2000 || o_i1 !== e_i1) begin errors++; $display("FAIL same_cycle_target: got pc=%h i1=%h expected 00002000 %h", o_pc, o_i1, e_i1); end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[2];
    int n;
    lat_min = 1; lat_max = 1;
    redir_v = 1; redir_pc_v = 32'hFFFF_FFFC;
    step();
    redir_v = 0;
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin step(); if (fired) begin addrs[n] = o_addr; n++; end end
    checks++; if (n < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0000_0002) begin errors++; $display("FAIL pc_wrap: got n=%0d %h %h expected fffffffc 00000002", n, addrs[0], addrs[1]); end
  endtask

  task automatic test_boot_redirect();
    reset_v = 1; step();
    reset_v = 0; redir_v = 1; redir_pc_v = 32'h40;
    step();
    redir_v = 0;
    checks++; if (o_fl !== 1'b1 || o_rv !== 1'b0 || o_wr !== 1'b0) begin errors++; $display("FAIL boot_redirect: got fl=%b rv=%b wr=%b expected 1 0 0", o_fl, o_rv, o_wr); end
    step();
    checks++; if (o_rv !== 1'b1 || o_addr !== 32'h40) begin errors++; $display("FAIL boot_redirect_fetch: got rv=%b addr=%h expected 1 00000040", o_rv, o_addr); end
  endtask

  task automatic test_reset_midstream();
    stall_v = 1; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20 && fq.size() < 2; i++) step();
    checks++; if (o_ov !== 1'b1) begin errors++; $display("FAIL midreset_setup: got out_valid=%b expected 1", o_ov); end
    reset_v = 1; step();
    reset_v = 0; step();
    checks++; if ({o_ov, o_rv, o_wr, o_fl} !== 4'b0000 || {o_pc, o_i1, o_i2} !== 80'h0) begin
      errors++; $display("FAIL midreset_boot: got ov/rv/wr/fl=%b pc=%h i1=%h i2=%h expected 0000 zeros", {o_ov, o_rv, o_wr, o_fl}, o_pc, o_i1, o_i2);
    end
    step();
    checks++; if (o_rv !== 1'b1 || o_addr !== RESET_PC) begin errors++; $display("FAIL midreset_restart: got rv=%b addr=%h expected 1 %h", o_rv, o_addr, RESET_PC); end
    stall_v = 0;
  endtask

  task automatic test_random();
    int pops;
    pops = 0; lat_min = 1; lat_max = 4; hold_pct = 20;
    for (int c = 0; c < 2000; c++) begin
      stall_v    = ($urandom_range(99) < 30);
      ready_v    = ($urandom_range(99) < 75);
      redir_v    = ($urandom_range(99) < 3);
      redir_pc_v = $urandom;
      step();
      if (popped) pops++;
      if (chk) begin
        checks++; if (o_ov !== e_ov) begin errors++; $display("FAIL rnd_out_valid c=%0d: got %b expected %b", c, o_ov, e_ov); end
        checks++; if (o_rv !== e_rv) begin errors++; $display("FAIL rnd_req_valid c=%0d: got %b expected %b", c, o_rv, e_rv); end
        if (e_rv) begin
          checks++; if (o_addr !== e_addr) begin errors++; $display("FAIL rnd_req_addr c=%0d: got %h expected %h", c, o_addr, e_addr); end
        end
        if (e_ov || e_empty) begin
          checks++; if ({o_pc, o_i1, o_i2} !== {e_pc, e_i1, e_i2}) begin errors++; $display("FAIL rnd_bundle c=%0d: got %h %h %h expected %h %h %h", c, o_pc, o_i1, o_i2, e_pc, e_i1, e_i2); end
        end
        checks++; if ({o_wr, o_fl} !== {e_wr, e_fl}) begin errors++; $display("FAIL rnd_ifid c=%0d: got wr/fl=%b expected %b", c, {o_wr, o_fl}, {e_wr, e_fl}); end
      end
    end
    checks++; if (pops < 100) begin errors++; $display("FAIL rnd_progress: got %0d bundles expected at least 100", pops); end
    redir_v = 0; stall_v = 0; ready_v = 1; hold_pct = 0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 48'h0;
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_rsp_same_cycle();
    test_wrap();
    test_boot_redirect();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
